// File: rtl/md_array_scan_ctrl.sv
// ---------------------------------------------------------------------------
// md_array_scan_ctrl
//   Sequencer for the multi-dimensional array passthrough datapath. When a
//   scan starts it snapshots a DIM x DIM x DIM array of WIDTH-bit elements.
//   It then streams one element per transfer on a valid/ready port. Each
//   element is tagged with its {k,j,i} index.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   start      request a scan; accepted only in IDLE
//   order      0: i fastest (k,j,i); 1: k fastest (i,j,k)
//   arr_in     input array, indexed [k][j][i]
//   busy       high in RUN and DONE
//   done       1-cycle pulse after the last element transfers
//   out_valid  element on out_data/out_idx is valid
//   out_ready  consumer accepts the element
//   out_data   snapshot element at out_idx
//   out_idx    {k,j,i} of the current element
//   out_last   high with out_valid on the final element (DIM-1,DIM-1,DIM-1)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: an element transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and no transfer happens,
// out_valid, out_data, out_idx and out_last hold stable. out_valid never
// depends combinationally on out_ready.
// ---------------------------------------------------------------------------
module md_array_scan_ctrl #(
  parameter  int WIDTH = 3,
  parameter  int DIM   = 3,
  localparam int IW    = $clog2(DIM)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        order,
  input  logic [DIM-1:0][DIM-1:0][DIM-1:0][WIDTH-1:0] arr_in,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [WIDTH-1:0]                            out_data,
  output logic [3*IW-1:0]                             out_idx,
  output logic                                        out_last,
  output logic [1:0]                                  dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  // Counters wrap at DIM-1, not at 2^IW-1, so non-power-of-2 DIM works.
  localparam logic [IW-1:0] IDX_MAX = IW'(DIM - 1);

  state_t                                      r_state;
  logic [DIM-1:0][DIM-1:0][DIM-1:0][WIDTH-1:0] r_snap;
  logic                                        r_order;
  logic [IW-1:0]                               r_k, r_j, r_i;
  logic                                        r_busy, r_done, r_valid, r_last;
  logic [WIDTH-1:0]                            r_data;

  logic          w_wrap_k, w_wrap_j, w_wrap_i;
  logic [IW-1:0] w_nk, w_nj, w_ni;
  logic          w_nlast;
  logic          w_xfer;

  assign w_xfer = r_valid & out_ready;

  // Next index in the selected scan order. The fastest counter always
  // advances. Each slower counter advances only when every faster one wraps.
  always_comb begin
    w_wrap_k = (r_k == IDX_MAX);
    w_wrap_j = (r_j == IDX_MAX);
    w_wrap_i = (r_i == IDX_MAX);
    w_nk     = r_k;
    w_nj     = r_j;
    w_ni     = r_i;
    if (!r_order) begin
      w_ni = w_wrap_i ? '0 : r_i + 1'b1;
      if (w_wrap_i) begin
        w_nj = w_wrap_j ? '0 : r_j + 1'b1;
        if (w_wrap_j) w_nk = w_wrap_k ? '0 : r_k + 1'b1;
      end
    end else begin
      w_nk = w_wrap_k ? '0 : r_k + 1'b1;
      if (w_wrap_k) begin
        w_nj = w_wrap_j ? '0 : r_j + 1'b1;
        if (w_wrap_j) w_ni = w_wrap_i ? '0 : r_i + 1'b1;
      end
    end
    w_nlast = (w_nk == IDX_MAX) && (w_nj == IDX_MAX) && (w_ni == IDX_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_order <= 1'b0;
      r_k     <= '0;
      r_j     <= '0;
      r_i     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_snap  <= arr_in;
            r_order <= order;
            r_k     <= '0;
            r_j     <= '0;
            r_i     <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            // DIM >= 2, so element (0,0,0) is never the last one.
            r_last  <= 1'b0;
            // The snapshot is not loaded yet, so the first element comes
            // straight from arr_in. It is still a registered value.
            r_data  <= arr_in[0][0][0];
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_k    <= w_nk;
              r_j    <= w_nj;
              r_i    <= w_ni;
              r_last <= w_nlast;
              r_data <= r_snap[w_nk][w_nj][w_ni];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = {r_k, r_j, r_i};
  assign out_last  = r_last;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_md_array_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_array_scan_ctrl
//   Directed bench for md_array_scan_ctrl. It instantiates a DIM=3/WIDTH=3
//   instance and a DIM=5/WIDTH=8 instance. Expected {idx,data,last} beats are
//   generated from nested loops over the array the bench drives. They are
//   queued when a scan starts and popped on every observed transfer.
// ---------------------------------------------------------------------------
module tb_md_array_scan_ctrl;

  localparam int W   = 3;
  localparam int D   = 3;
  localparam int IW  = 2;
  localparam int W5  = 8;
  localparam int D5  = 5;
  localparam int IW5 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DIM=3 instance ----------------
  logic                              start, order, out_ready;
  logic [D-1:0][D-1:0][D-1:0][W-1:0] arr_in;
  logic                              busy, done, out_valid, out_last;
  logic [W-1:0]                      out_data;
  logic [3*IW-1:0]                   out_idx;
  logic [1:0]                        dbg_state;

  md_array_scan_ctrl #(.WIDTH(W), .DIM(D)) dut (
    .clk(clk), .rst(rst), .start(start), .order(order), .arr_in(arr_in),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  // ---------------- DIM=5 instance ----------------
  logic                                  start5, order5, out_ready5;
  logic [D5-1:0][D5-1:0][D5-1:0][W5-1:0] arr5;
  logic                                  busy5, done5, out_valid5, out_last5;
  logic [W5-1:0]                         out_data5;
  logic [3*IW5-1:0]                      out_idx5;
  logic [1:0]                            dbg_state5;

  md_array_scan_ctrl #(.WIDTH(W5), .DIM(D5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .order(order5), .arr_in(arr5),
    .busy(busy5), .done(done5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_data(out_data5), .out_idx(out_idx5), .out_last(out_last5),
    .dbg_state(dbg_state5)
  );

  // ---------------- scoreboard ----------------
  logic [3*IW+W:0]                   exp_q[$];   // {idx, data, last}
  logic [3*IW5+W5:0]                 exp5_q[$];
  logic [D-1:0][D-1:0][D-1:0][W-1:0] model_arr;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference array: element [k][j][i] = (9k+3j+i) % 8.
  task automatic set_arr();
    for (int k = 0; k < D; k++)
      for (int j = 0; j < D; j++)
        for (int i = 0; i < D; i++)
          model_arr[k][j][i] = W'((9*k + 3*j + i) % 8);
    arr_in = model_arr;
  endtask

  task automatic load_expected(input logic ord);
    exp_q.delete();
    for (int a = 0; a < D; a++)
      for (int b = 0; b < D; b++)
        for (int c = 0; c < D; c++) begin
          int k, j, i;
          logic l;
          if (!ord) begin k = a; j = b; i = c; end
          else      begin i = a; j = b; k = c; end
          l = (k == D-1) && (j == D-1) && (i == D-1);
          exp_q.push_back({IW'(k), IW'(j), IW'(i), model_arr[k][j][i], l});
        end
  endtask

  // Full scan on the DIM=3 instance. stall: random out_ready; poke: change
  // arr_in and pulse start mid-scan, and pulse start in the DONE cycle.
  task automatic run_scan(input logic ord, input bit stall, input bit poke);
    logic [W-1:0]    hd;
    logic [3*IW-1:0] hi;
    logic            hl;
    bit              held;
    logic [3*IW+W:0] e;
    int              beats, cycles;
    load_expected(ord);
    @(negedge clk);
    order = ord; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    order = ~ord;
    chk("first_valid", out_valid, 1);
    chk("first_idx", out_idx, 0);
    chk("busy_run", busy, 1);
    chk("state_run", dbg_state, 1);
    beats = 0; cycles = 0; held = 0; hd = '0; hi = '0; hl = 1'b0;
    while (beats < D*D*D && cycles < 400) begin
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hd);
        chk("stall_idx", out_idx, hi);
        chk("stall_last", out_last, hl);
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && cycles == 4) begin arr_in = '1; start = 1'b1; end
      if (poke && cycles == 5) start = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", out_idx, e[3*IW+W:W+1]);
          chk("beat_data", out_data, e[W:1]);
          chk("beat_last", out_last, e[0]);
        end
        beats++;
        held = 0;
      end else begin
        held = out_valid;
        hd = out_data; hi = out_idx; hl = out_last;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk("beat_count", beats, D*D*D);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("valid_done", out_valid, 0);
    chk("state_done", dbg_state, 2);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("state_idle", dbg_state, 0);
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_second_done", done, 0);
        chk("no_second_scan", busy, 0);
      end
    end
    chk("queue_empty", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3*IW5+W5:0] e5;
    int beats5, cycles5;
    rst = 1'b1; start = 1'b0; order = 1'b0; out_ready = 1'b1; arr_in = '0;
    start5 = 1'b0; order5 = 1'b0; out_ready5 = 1'b1; arr5 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_state", dbg_state, 0);

    // order 0 and order 1, continuous ready
    set_arr(); run_scan(1'b0, 0, 0);
    set_arr(); run_scan(1'b1, 0, 0);
    // random back-pressure, both orders
    set_arr(); run_scan(1'b0, 1, 0);
    set_arr(); run_scan(1'b1, 1, 0);
    // arr_in change and start pulses during RUN and DONE
    set_arr(); run_scan(1'b0, 0, 1);

    // reset on beat 10 aborts the scan
    set_arr();
    @(negedge clk);
    order = 1'b0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_idx", out_idx, {2'd1, 2'd0, 2'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_data", out_data, 0);
    chk("abort_idx", out_idx, 0);
    chk("abort_last", out_last, 0);
    chk("abort_state", dbg_state, 0);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    set_arr(); run_scan(1'b0, 0, 0);

    // DIM=5 instance, order 0, random data
    for (int k = 0; k < D5; k++)
      for (int j = 0; j < D5; j++)
        for (int i = 0; i < D5; i++)
          arr5[k][j][i] = W5'($urandom_range(0, 255));
    exp5_q.delete();
    for (int k = 0; k < D5; k++)
      for (int j = 0; j < D5; j++)
        for (int i = 0; i < D5; i++)
          exp5_q.push_back({IW5'(k), IW5'(j), IW5'(i), arr5[k][j][i],
                            1'((k == D5-1) && (j == D5-1) && (i == D5-1))});
    @(negedge clk);
    order5 = 1'b0; start5 = 1'b1; out_ready5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    beats5 = 0; cycles5 = 0;
    while (beats5 < D5*D5*D5 && cycles5 < 400) begin
      if (out_valid5 && out_ready5) begin
        if (exp5_q.size() == 0) begin
          chk("d5_extra_beat", 1, 0);
        end else begin
          e5 = exp5_q.pop_front();
          chk("d5_idx", out_idx5, e5[3*IW5+W5:W5+1]);
          chk("d5_data", out_data5, e5[W5:1]);
          chk("d5_last", out_last5, e5[0]);
        end
        beats5++;
      end
      @(negedge clk);
      cycles5++;
    end
    chk("d5_beat_count", beats5, D5*D5*D5);
    chk("d5_done", done5, 1);
    chk("d5_valid_done", out_valid5, 0);
    @(negedge clk);
    chk("d5_idle", dbg_state5, 0);
    chk("d5_queue_empty", exp5_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
